// File: rtl/button_ctrl.sv
// rtl/button_ctrl.sv - debounced push-button controller with sticky press capture and maskable irq
module button_ctrl #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int ACTIVE_LOW      = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    localparam int              CW       = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [WIDTH-1:0] RELEASED = {WIDTH{ACTIVE_LOW != 0}};

    typedef enum logic {DB_STABLE, DB_COUNTING} db_state_t;

    logic [WIDTH-1:0] sync1_q, sync2_q, raw;
    logic [WIDTH-1:0] stable_q, stable_d;
    logic [WIDTH-1:0] edge_q, edge_d, mask_q, clr, press;
    logic [CW-1:0]    cnt_q [WIDTH];
    logic [CW-1:0]    cnt_d [WIDTH];
    db_state_t        state_q [WIDTH];
    db_state_t        state_d [WIDTH];
    logic             wr_en;

    assign wr_en = chipselect & write;
    // XOR with the released level turns every pin into 1 = pressed
    assign raw   = sync2_q ^ RELEASED;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        stable_d = stable_q;
        for (int i = 0; i < WIDTH; i++) begin
            case (state_q[i])
                DB_STABLE: begin
                    if (raw[i] != stable_q[i]) begin
                        state_d[i] = DB_COUNTING;
                        cnt_d[i]   = CNT_ONE;
                    end
                end
                DB_COUNTING: begin
                    if (raw[i] == stable_q[i]) begin
                        state_d[i] = DB_STABLE;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == CNT_LAST) begin
                        stable_d[i] = raw[i];
                        state_d[i]  = DB_STABLE;
                        cnt_d[i]    = '0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_ONE;
                    end
                end
                default: begin
                    state_d[i] = DB_STABLE;
                    cnt_d[i]   = '0;
                end
            endcase
        end
    end

    // a press in the same cycle as a W1C clear wins
    always_comb begin
        press  = stable_d & ~stable_q;
        clr    = (wr_en && address == 2'd3) ? writedata[WIDTH-1:0] : '0;
        edge_d = (edge_q & ~clr) | press;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q  <= RELEASED;
            sync2_q  <= RELEASED;
            stable_q <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                state_q[i] <= DB_STABLE;
                cnt_q[i]   <= '0;
            end
        end else begin
            sync1_q  <= in_port;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            for (int i = 0; i < WIDTH; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            edge_q   <= '0;
            mask_q   <= '0;
            irq      <= 1'b0;
            readdata <= '0;
        end else begin
            edge_q <= edge_d;
            if (wr_en && address == 2'd2) begin
                mask_q <= writedata[WIDTH-1:0];
            end
            irq <= |(edge_q & mask_q);
            case (address)
                2'd0:    readdata <= 32'(stable_q);
                2'd1:    readdata <= 32'(raw);
                2'd2:    readdata <= 32'(mask_q);
                default: readdata <= 32'(edge_q);
            endcase
        end
    end

endmodule

// File: tb/tb_button_ctrl.sv
// tb/tb_button_ctrl.sv - randomized bench for button_ctrl against a sample-history reference model
module tb_button_ctrl;

    localparam int W  = 4;
    localparam int DC = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [W-1:0] in_port;
    logic        irq;

    int n_checks = 0;
    int n_pass   = 0;

    // reference state: pin delay line, last DC pressed-samples, registers
    logic [W-1:0] m_pd1, m_pd2, m_stable, m_edge, m_mask;
    logic [W-1:0] m_hist [DC];
    logic [31:0]  m_rd;
    logic         m_irq;

    button_ctrl #(.WIDTH(W), .DEBOUNCE_CYCLES(DC), .ACTIVE_LOW(1)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write      (write),
        .writedata  (writedata),
        .readdata   (readdata),
        .in_port    (in_port),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_pd1 = '1;
        m_pd2 = '1;
        m_stable = '0;
        m_edge = '0;
        m_mask = '0;
        m_rd = '0;
        m_irq = 1'b0;
        for (int j = 0; j < DC; j++) m_hist[j] = '0;
    endtask

    // a level is accepted once the last DC samples all disagree with it
    task automatic model_step(input logic [1:0] a, input logic cs, input logic wr,
                              input logic [31:0] wd, input logic [W-1:0] pins);
        logic [W-1:0] raw, nstable, press, nedge;
        logic [31:0]  nrd;
        int diff;
        raw = ~m_pd2;
        for (int j = DC - 1; j > 0; j--) m_hist[j] = m_hist[j-1];
        m_hist[0] = raw;
        nstable = m_stable;
        for (int b = 0; b < W; b++) begin
            diff = 0;
            for (int j = 0; j < DC; j++) if (m_hist[j][b] != m_stable[b]) diff++;
            if (diff == DC) nstable[b] = ~m_stable[b];
        end
        press = nstable & ~m_stable;
        nedge = m_edge;
        if (cs && wr && a == 2'd3) nedge = nedge & ~wd[W-1:0];
        nedge = nedge | press;
        m_irq = |(m_edge & m_mask);
        case (a)
            2'd0:    nrd = {28'b0, m_stable};
            2'd1:    nrd = {28'b0, raw};
            2'd2:    nrd = {28'b0, m_mask};
            default: nrd = {28'b0, m_edge};
        endcase
        if (cs && wr && a == 2'd2) m_mask = wd[W-1:0];
        m_edge = nedge;
        m_stable = nstable;
        m_rd = nrd;
        m_pd2 = m_pd1;
        m_pd1 = pins;
    endtask

    task automatic cyc(input logic [1:0] a, input logic cs, input logic wr,
                       input logic [31:0] wd, input logic [W-1:0] pins);
        address = a;
        chipselect = cs;
        write = wr;
        writedata = wd;
        in_port = pins;
        @(posedge clk);
        model_step(a, cs, wr, wd, pins);
        @(negedge clk);
        check("readdata", readdata, m_rd);
        check("irq", {31'b0, irq}, {31'b0, m_irq});
    endtask

    task automatic apply_reset(input int hold);
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_readdata", readdata, 32'h0);
        check("async_rst_irq", {31'b0, irq}, 32'h0);
        model_reset();
        repeat (hold) @(negedge clk);
        reset_n = 1'b1;
    endtask

    logic [W-1:0] tgt, pins;

    initial begin
        reset_n = 1'b0;
        address = '0;
        chipselect = 1'b0;
        write = 1'b0;
        writedata = '0;
        in_port = 4'hF;
        model_reset();
        repeat (3) @(negedge clk);
        check("reset_readdata", readdata, 32'h0);
        check("reset_irq", {31'b0, irq}, 32'h0);
        reset_n = 1'b1;
        for (int a = 0; a < 4; a++) begin
            cyc(2'(a), 1'b0, 1'b0, 32'h0, 4'hF);
            check("post_reset_reg", readdata, 32'h0);
        end

        // clean press on bit 0 with MASK=1
        cyc(2'd2, 1'b1, 1'b1, 32'h1, 4'hF);
        for (int i = 0; i <= 6; i++) begin
            cyc(2'd0, 1'b0, 1'b0, 32'h0, 4'hE);
            if (i == 5) begin
                check("press_data_early", readdata, 32'h0);
                check("press_irq_early", {31'b0, irq}, 32'h0);
            end
            if (i == 6) begin
                check("press_data", readdata, 32'h1);
                check("press_irq", {31'b0, irq}, 32'h1);
            end
        end
        cyc(2'd3, 1'b1, 1'b1, 32'h1, 4'hE);
        cyc(2'd3, 1'b0, 1'b0, 32'h0, 4'hE);
        check("clear_edge", readdata, 32'h0);
        check("clear_irq", {31'b0, irq}, 32'h0);

        // bounce on bit 2, then a genuine press
        for (int i = 0; i < 2; i++) cyc(2'd1, 1'b0, 1'b0, 32'h0, 4'hA);
        for (int i = 0; i < 8; i++) cyc(2'(i % 2 == 0 ? 1 : 3), 1'b0, 1'b0, 32'h0, 4'hE);
        for (int i = 0; i < 9; i++) cyc(2'(i % 4), 1'b0, 1'b0, 32'h0, 4'hA);

        // masked press on bit 3, then unmask
        cyc(2'd2, 1'b1, 1'b1, 32'h0, 4'hA);
        cyc(2'd3, 1'b1, 1'b1, 32'hF, 4'hA);
        for (int i = 0; i < 9; i++) cyc(2'd3, 1'b0, 1'b0, 32'h0, 4'h2);
        check("masked_edge", readdata, 32'h8);
        cyc(2'd2, 1'b1, 1'b1, 32'h8, 4'h2);
        cyc(2'd2, 1'b0, 1'b0, 32'h0, 4'h2);
        cyc(2'd2, 1'b0, 1'b0, 32'h0, 4'h2);
        check("unmask_irq", {31'b0, irq}, 32'h1);

        // clear of bit 1 lands on the edge where its debounce completes
        cyc(2'd3, 1'b1, 1'b1, 32'hF, 4'h2);
        for (int i = 0; i < 5; i++) cyc(2'd0, 1'b0, 1'b0, 32'h0, 4'h0);
        cyc(2'd3, 1'b1, 1'b1, 32'h2, 4'h0);
        cyc(2'd3, 1'b0, 1'b0, 32'h0, 4'h0);
        check("collision_edge1", readdata & 32'h2, 32'h2);

        // release everything, then reset in the middle of counting a press
        for (int i = 0; i < 10; i++) cyc(2'(i % 4), 1'b0, 1'b0, 32'h0, 4'hF);
        for (int i = 0; i < 3; i++) cyc(2'd0, 1'b0, 1'b0, 32'h0, 4'hE);
        apply_reset(2);
        for (int i = 0; i <= 6; i++) begin
            cyc(2'd0, 1'b0, 1'b0, 32'h0, 4'hE);
            if (i == 5) check("rst_hold_data_early", readdata, 32'h0);
            if (i == 6) check("rst_hold_data", readdata, 32'h1);
        end

        // random bouncing buttons with random bus traffic
        tgt = 4'hE;
        for (int c = 0; c < 600; c++) begin
            for (int b = 0; b < W; b++) begin
                if ($urandom_range(19) == 0) tgt[b] = ~tgt[b];
                pins[b] = ($urandom_range(5) == 0) ? ~tgt[b] : tgt[b];
            end
            if (c == 300) apply_reset(1 + $urandom_range(2));
            cyc(2'($urandom_range(3)), 1'($urandom_range(1)), ($urandom_range(7) == 0),
                $urandom, pins);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
